spi_regfile_peripheral: RTL and testbench

- Parametrised SPI mode-0 target giving the system a register file of NUM_REGS x DATA_W bits, with write and read-back.
- Successor to the fixed 5 x 8-bit write-only peripheral: generalised address/data widths and register count, adds an SDO read path, a per-write strobe and frame-error reporting.
- Sits between the chip pins and the PWM/output-enable logic, which consumes the flat reg_q bus.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_regfile_peripheral.sv | 193 +++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and frame-width helper for the SPI register-file peripheral.
package spi_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target exposing a NUM_REGS x DATA_W register file with write commit and frame-error pulses.
// Define SPI_READBACK_EN to build the SDO read path; otherwise sdo/sdo_oe are tied low.
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         sdi,
    output logic                         sdo,
    output logic                         sdo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic ncs_sync, ncs_rise, ncs_fall;
    logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_in(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_in(ncs),
        .q(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .d_in(sdi),
        .q(sdi_sync), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]                rx_q, rx_d, rx_next;
    logic [ADDR_W-1:0]                 pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]                 pend_data_q, pend_data_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic                              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]                 wr_addr_q, wr_addr_d;
    logic                              frame_err_q, frame_err_d;
    logic [1:0]                        arm_q, arm_d;

    logic              f_rw;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;
    logic              addr_ok;

    assign rx_next = {rx_q[FRAME_W-2:0], sdi_sync};
    assign f_rw    = rx_q[FRAME_W-1];
    assign f_addr  = rx_q[FRAME_W-2 -: ADDR_W];
    assign f_data  = rx_q[DATA_W-1:0];
    assign addr_ok = 32'(f_addr) < NUM_REGS;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        // The synchroniser comes out of reset at ncs=1, so a frame already in
        // progress shows a spurious ncs fall two cycles later; ignore it.
        arm_d       = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (ncs_fall && arm_q == 2'd3) state_d = SHIFT;
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    if (bit_cnt_q != CNT_FULL) begin
                        frame_err_d = 1'b1;
                    end else if (f_rw == RW_WRITE && addr_ok) begin
                        state_d     = COMMIT;
                        pend_addr_d = f_addr;
                        pend_data_d = f_data;
                    end
                end else if (sclk_rise && !ncs_sync) begin
                    rx_d = rx_next;
                    if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (32'(pend_addr_q) == i) regs_d[i] = pend_data_q;
                end
                wr_strobe_d = 1'b1;
                wr_addr_d   = pend_addr_q;
                state_d     = ncs_fall ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            arm_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            arm_q       <= arm_d;
        end
    end

    assign reg_q     = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(1 + ADDR_W);

    logic [DATA_W-1:0] tx_q, tx_d, rd_val;
    logic              sdo_q, sdo_d;

    always_comb begin
        tx_d   = tx_q;
        sdo_d  = sdo_q;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rx_next[ADDR_W-1:0]) == i) rd_val = regs_q[i];
        end
        if (state_q != SHIFT || ncs_rise) begin
            tx_d  = '0;
            sdo_d = 1'b0;
        end else if (sclk_rise && !ncs_sync && bit_cnt_q == CNT_HDR - CNT_W'(1)) begin
            // Write frames leave tx zero, so the data phase drives 0 for them.
            tx_d = (rx_next[ADDR_W] == RW_READ) ? rd_val : '0;
        end else if (sclk_fall) begin
            if (bit_cnt_q >= CNT_HDR && bit_cnt_q < CNT_FULL) begin
                sdo_d = tx_q[DATA_W-1];
                tx_d  = tx_q << 1;
            end else begin
                sdo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q  <= '0;
            sdo_q <= 1'b0;
        end else begin
            tx_q  <= tx_d;
            sdo_q <= sdo_d;
        end
    end

    assign sdo    = sdo_q;
    assign sdo_oe = !ncs_sync;
`else
    logic sclk_fall_unused;
    assign sclk_fall_unused = sclk_fall;
    assign sdo    = 1'b0;
    assign sdo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench: two peripheral instances (default and 4/16/16) driven by a shared SPI controller model.
module tb_spi_regfile_peripheral;

    localparam int HALF = 6;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, sdi = 1'b0, ncs0 = 1'b1, ncs1 = 1'b1;
    logic sdo0, oe0, stb0, fe0, sdo1, oe1, stb1, fe1;
    logic [39:0]  rq0;
    logic [255:0] rq1;
    logic [6:0]   wa0;
    logic [3:0]   wa1;

    always #5 clk = ~clk;

    spi_regfile_peripheral u0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs0), .sdi(sdi),
        .sdo(sdo0), .sdo_oe(oe0), .reg_q(rq0), .wr_strobe(stb0),
        .wr_addr(wa0), .frame_err(fe0)
    );
    spi_regfile_peripheral #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16)) u1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs1), .sdi(sdi),
        .sdo(sdo1), .sdo_oe(oe1), .reg_q(rq1), .wr_strobe(stb1),
        .wr_addr(wa1), .frame_err(fe1)
    );

    int checks = 0, failures = 0;
    logic [7:0]  m0 [5];
    logic [15:0] m1 [16];
    int exp_stb [2], exp_err [2], exp_wa [2];
    int stb_cnt [2], err_cnt [2];
    int long_cnt = 0;
    bit held [2];
    logic pstb0 = 1'b0, pstb1 = 1'b0;

    always @(negedge clk) begin
        if (stb0) stb_cnt[0]++;
        if (stb1) stb_cnt[1]++;
        if (fe0) err_cnt[0]++;
        if (fe1) err_cnt[1]++;
        if ((stb0 && pstb0) || (stb1 && pstb1)) long_cnt++;
        pstb0 = stb0;
        pstb1 = stb1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int inst, input bit rw, input int addr, input int data);
        int a, d;
        a = inst ? 4 : 7;
        d = inst ? 16 : 8;
        return (32'(rw) << (a + d)) | (32'(addr) << d) | 32'(data);
    endfunction

    task automatic set_ncs(input int inst, input logic v);
        if (inst != 0) ncs1 = v;
        else ncs0 = v;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        wait_clk(3);
        checks++;
        if ({rq0, rq1, wa0, wa1, stb0, stb1, fe0, fe1, sdo0, sdo1, oe0, oe1} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got rq0=%h wa0=%h stb0=%b fe0=%b sdo0=%b oe0=%b required all zero",
                     rq0, wa0, stb0, fe0, sdo0, oe0);
        end
        for (int i = 0; i < 5; i++) m0[i] = '0;
        for (int i = 0; i < 16; i++) m1[i] = '0;
        exp_wa[0] = 0;
        exp_wa[1] = 0;
        rst_n = 1'b1;
    endtask

    // Drives one frame of n bits (val[n-1] first) and updates the reference model.
    task automatic frame(input int inst, input int n, input logic [31:0] val,
                         input bit b2b, input int rst_bit);
        int a, d, nr, fw, addr;
        bit rw;
        logic [31:0] data, rdv;
        logic exp_b, got_b;
        a = inst ? 4 : 7;
        d = inst ? 16 : 8;
        nr = inst ? 16 : 5;
        fw = 1 + a + d;
        rw = val[fw-1];
        addr = int'((val >> d) & ((32'd1 << a) - 32'd1));
        data = val & ((32'd1 << d) - 32'd1);
        rdv = '0;
        if (RB && !rw && addr < nr) rdv = inst ? 32'(m1[addr]) : 32'(m0[addr]);
        if (!held[inst]) set_ncs(inst, 1'b0);
        held[inst] = 1'b0;
        wait_clk(HALF);
        got_b = inst ? oe1 : oe0;
        checks++;
        if (got_b !== RB) begin
            failures++;
            $display("FAIL sdo_oe_in_frame inst=%0d got=%b required=%b", inst, got_b, RB);
        end
        for (int k = 0; k < n; k++) begin
            sdi = val[n-1-k];
            wait_clk(HALF);
            if (n == fw && k > a) begin
                exp_b = rdv[d-1-(k-1-a)];
                got_b = inst ? sdo1 : sdo0;
                checks++;
                if (got_b !== exp_b) begin
                    failures++;
                    $display("FAIL sdo_bit inst=%0d addr=%0d bit=%0d got=%b required=%b",
                             inst, addr, k-1-a, got_b, exp_b);
                end
            end
            if (k == rst_bit) mid_reset();
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        set_ncs(inst, 1'b1);
        if (b2b) begin
            wait_clk(1);
            set_ncs(inst, 1'b0);
            held[inst] = 1'b1;
        end
        if (rst_bit < 0) begin
            if (n != fw) begin
                exp_err[inst]++;
            end else if (rw && addr < nr) begin
                if (inst != 0) m1[addr] = data[15:0];
                else m0[addr] = data[7:0];
                exp_stb[inst]++;
                exp_wa[inst] = addr;
            end
        end
    endtask

    task automatic settle_check(input string tag);
        logic [39:0]  e0;
        logic [255:0] e1;
        wait_clk(12);
        for (int i = 0; i < 5; i++) e0[i*8 +: 8] = m0[i];
        for (int i = 0; i < 16; i++) e1[i*16 +: 16] = m1[i];
        checks++;
        if (rq0 !== e0) begin
            failures++;
            $display("FAIL %s reg_q0 got=%h required=%h", tag, rq0, e0);
        end
        checks++;
        if (rq1 !== e1) begin
            failures++;
            $display("FAIL %s reg_q1 got=%h required=%h", tag, rq1, e1);
        end
        checks++;
        if (stb_cnt[0] != exp_stb[0] || stb_cnt[1] != exp_stb[1]) begin
            failures++;
            $display("FAIL %s strobe_count got=%0d/%0d required=%0d/%0d", tag,
                     stb_cnt[0], stb_cnt[1], exp_stb[0], exp_stb[1]);
        end
        checks++;
        if (err_cnt[0] != exp_err[0] || err_cnt[1] != exp_err[1]) begin
            failures++;
            $display("FAIL %s frame_err_count got=%0d/%0d required=%0d/%0d", tag,
                     err_cnt[0], err_cnt[1], exp_err[0], exp_err[1]);
        end
        checks++;
        if (long_cnt != 0) begin
            failures++;
            $display("FAIL %s strobe_width got=%0d multi-cycle pulses required=0", tag, long_cnt);
        end
        checks++;
        if (int'(wa0) != exp_wa[0] || int'(wa1) != exp_wa[1]) begin
            failures++;
            $display("FAIL %s wr_addr got=%0d/%0d required=%0d/%0d", tag, wa0, wa1, exp_wa[0], exp_wa[1]);
        end
        checks++;
        if ({oe0, oe1, sdo0, sdo1} !== 4'b0) begin
            failures++;
            $display("FAIL %s idle_sdo got oe=%b%b sdo=%b%b required 0", tag, oe0, oe1, sdo0, sdo1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) m0[i] = '0;
        for (int i = 0; i < 16; i++) m1[i] = '0;
        wait_clk(4);
        checks++;
        if ({rq0, wa0, stb0, fe0, sdo0, oe0} !== '0) begin
            failures++;
            $display("FAIL reset_u0 got rq=%h wa=%h stb=%b fe=%b required all zero", rq0, wa0, stb0, fe0);
        end
        checks++;
        if ({rq1, wa1, stb1, fe1, sdo1, oe1} !== '0) begin
            failures++;
            $display("FAIL reset_u1 got rq=%h wa=%h stb=%b fe=%b required all zero", rq1, wa1, stb1, fe1);
        end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write_basic();
        frame(0, 16, mk(0, 1, 4, 'hA5), 1'b0, -1);
        settle_check("write_basic");
        checks++;
        if (rq0[39:32] !== 8'hA5 || wa0 !== 7'd4) begin
            failures++;
            $display("FAIL write_basic_a5 got reg4=%h wr_addr=%0d required reg4=a5 wr_addr=4", rq0[39:32], wa0);
        end
    endtask

    task automatic test_readback();
        frame(0, 16, mk(0, 1, 1, 'h3C), 1'b0, -1);
        settle_check("write_3c");
        frame(0, 16, mk(0, 0, 1, 0), 1'b0, -1);
        settle_check("read_3c");
    endtask

    task automatic test_out_of_range();
        frame(0, 16, mk(0, 1, 'h10, 'h99), 1'b0, -1);
        settle_check("write_oor");
        frame(0, 16, mk(0, 0, 'h10, 0), 1'b0, -1);
        settle_check("read_oor");
    endtask

    task automatic test_bad_length();
        frame(0, 10, $urandom, 1'b0, -1);
        settle_check("short_frame");
        frame(0, 17, $urandom, 1'b0, -1);
        settle_check("overflow_frame");
    endtask

    task automatic test_reset_mid_frame();
        frame(0, 16, mk(0, 1, 2, 'h11), 1'b0, 12);
        settle_check("reset_mid_frame");
        frame(0, 16, mk(0, 1, 2, 'h77), 1'b0, -1);
        settle_check("write_after_reset");
        checks++;
        if (rq0[23:16] !== 8'h77) begin
            failures++;
            $display("FAIL write_77 got=%h required=77", rq0[23:16]);
        end
    endtask

    task automatic test_wide();
        frame(1, 21, mk(1, 1, 15, 'hBEEF), 1'b0, -1);
        settle_check("wide_write");
        checks++;
        if (rq1[255:240] !== 16'hBEEF) begin
            failures++;
            $display("FAIL wide_beef got=%h required=beef", rq1[255:240]);
        end
        frame(1, 21, mk(1, 0, 15, 0), 1'b0, -1);
        settle_check("wide_read");
    endtask

    task automatic test_back_to_back();
        frame(0, 16, mk(0, 1, 3, 'h5A), 1'b1, -1);
        frame(0, 16, mk(0, 1, 0, 'hC3), 1'b0, -1);
        settle_check("back_to_back");
    endtask

    task automatic test_random();
        int inst, fw, n, addr;
        bit rw;
        for (int it = 0; it < 30; it++) begin
            inst = $urandom_range(0, 1);
            fw = inst ? 21 : 16;
            rw = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, inst ? 15 : 7);
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, fw + 3) : fw;
            frame(inst, n, mk(inst, rw, addr, int'($urandom & (inst ? 32'hFFFF : 32'hFF))), 1'b0, -1);
            settle_check("random");
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_readback();
        test_out_of_range();
        test_bad_length();
        test_reset_mid_frame();
        test_wide();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
